mem_access_ctrl: RTL and testbench
==================================

// Module: mem_access_ctrl
// PURPOSE
//  M-stage data-memory access controller, directly downstream of the E-stage dual-issue memory arbiter.
//  Registers the single arbitrated E-stage request into M and runs it on the SRAM-like data bus (req/addr_ok/data_ok).
//  Stalls the pipeline until the access completes.
//  Returns the aligned, sign/zero-extended load word that the arbiter splits back to slot A/B.
// PARAMETERS
//  ADDR_W  32  bus address width (fixed 32 for MIPS32; kept for bench reuse)
// PORTS
//  clk            in   1   single clock, all state on posedge
//  rst            in   1   synchronous, active-high reset
//  M_ena          in   1   E->M pipeline register advance
//  M_flush        in   1   kill M-stage contents (exception/eret)
//  E_mem_en       in   1   arbitrated access valid (already exception-masked)
//  E_mem_ren      in   1   load
//  E_mem_wen      in   1   store
//  E_mem_op       in   6   OP_LB/LBU/LH/LHU/LW/SB/SH/SW (shared OP_* defines)
//  E_mem_addr     in   32  byte address (alignment already checked upstream)
//  E_mem_wdata    in   32  store data, low-aligned
//  data_req       out  1   bus request
//  data_wr        out  1   1=write
//  data_size      out  2   0=byte 1=half 2=word
//  data_addr      out  32  byte address
//  data_wdata     out  32  lane-replicated store data
//  data_addr_ok   in   1   request accepted
//  data_data_ok   in   1   read data valid / write done
//  data_rdata     in   32  raw read word
//  M_mem_rdata    out  32  extended load result (to arbiter)
//  d_stall        out  1   M-stage access incomplete; holds pipeline
// BEHAVIOUR
//  Reset: all outputs 0; M_valid=0; cancel=0; state=IDLE.
//  M regs (valid/ren/wen/op/addr/wdata), priority rst > M_flush > M_ena:
//  - M_flush: M_valid<=0.
//  - M_ena: M_valid<=E_mem_en; other fields load unconditionally.
//  E_mem_en is never gated by M_ena or d_stall (avoids a comb loop).
//  FSM IDLE/REQ/WAIT/DONE; d_stall = M_valid & (state!=DONE).
//  - IDLE: if M_valid -> REQ.
//  - REQ: data_req=1, bus fields from M regs held stable.
//    addr_ok & data_ok -> DONE (or IDLE if cancel).
//    addr_ok & !data_ok -> WAIT.
//  - WAIT: data_req=0; data_ok -> DONE and capture rdata (IDLE if cancel).
//  - DONE: M_mem_rdata held from capture register.
//    On M_ena: -> REQ if new op valid, else IDLE.
//  A request cannot be withdrawn once data_req is high.
//  Flush in REQ/WAIT sets cancel; the bus transaction completes and the data is dropped.
//  cancel clears on its data_ok.
//  While cancel=1 a newly loaded op waits in IDLE; it never issues before the cancelled data_ok.
//  Size: B ops 0, H ops 1, W ops 2; data_wr=M_wen.
//  data_wdata: SB {4{wd[7:0]}}, SH {2{wd[15:0]}}, SW wd.
//  Load extract by addr[1:0]:
//  - LB/LBU: byte lane addr[1:0], sign/zero extend.
//  - LH/LHU: half addr[1].
//  - LW: word.
//  Extraction is applied at capture. Stores leave M_mem_rdata at 0.
//  Minimum latency: one stall cycle (addr_ok & data_ok in the REQ cycle). Each bus wait cycle adds one stall cycle.
//  Back-to-back ops: DONE with M_ena and a valid op goes straight to REQ; no idle bubble.
// TESTING
//  - LW 0x1000, bus returns addr_ok+data_ok same cycle, rdata=0xDEADBEEF -> 1 stall cycle, M_mem_rdata=0xDEADBEEF.
//  - LB addr=0x1003, rdata=0x80FF_0000 -> 0xFFFFFF80; LBU same -> 0x00000080; LH 0x1002 -> 0xFFFF80FF.
//  - SH addr=0x2002, wdata=0x1234ABCD -> data_wdata=0xABCDABCD, size=1, wr=1; addr_ok delayed 3 cycles -> data_req and fields held stable, d_stall=1 for 4+ cycles.
//  - M_flush in WAIT, new LW loaded next cycle -> no second data_req until cancelled data_ok; new LW then returns correct data.
//  - Back-to-back LW/SW with bus always ready -> each op stalls exactly 1 cycle, no extra IDLE cycle.
//  - rst asserted in WAIT -> next cycle state=IDLE, data_req=0, d_stall=0, M_mem_rdata=0.

Source files
------------

// File: rtl/mem_access_ctrl_if.sv
// Data-memory bus between the M-stage access controller and the SRAM-like port.
// Master drives the request; slave answers with addr_ok/data_ok/rdata.
interface mem_access_ctrl_if #(
    parameter int ADDR_W = 32
);
    logic              data_req;
    logic              data_wr;
    logic [1:0]        data_size;
    logic [ADDR_W-1:0] data_addr;
    logic [31:0]       data_wdata;
    logic              data_addr_ok;
    logic              data_data_ok;
    logic [31:0]       data_rdata;

    modport master (
        output data_req, data_wr, data_size, data_addr, data_wdata,
        input  data_addr_ok, data_data_ok, data_rdata
    );

    modport slave (
        input  data_req, data_wr, data_size, data_addr, data_wdata,
        output data_addr_ok, data_data_ok, data_rdata
    );
endinterface

// File: rtl/mem_access_ctrl.sv
// M-stage data-memory access controller: registers the arbitrated E-stage
// access, runs it on the data bus, stalls until done, returns extended load data.
module mem_access_ctrl #(
    parameter int ADDR_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              M_ena,
    input  logic              M_flush,
    input  logic              E_mem_en,
    input  logic              E_mem_ren,
    input  logic              E_mem_wen,
    input  logic [5:0]        E_mem_op,
    input  logic [ADDR_W-1:0] E_mem_addr,
    input  logic [31:0]       E_mem_wdata,
    mem_access_ctrl_if.master bus,
    output logic [31:0]       M_mem_rdata,
    output logic              d_stall
);
    localparam logic [5:0] OP_LB  = 6'd1;
    localparam logic [5:0] OP_LBU = 6'd2;
    localparam logic [5:0] OP_LH  = 6'd3;
    localparam logic [5:0] OP_LHU = 6'd4;
    localparam logic [5:0] OP_LW  = 6'd5;
    localparam logic [5:0] OP_SB  = 6'd6;
    localparam logic [5:0] OP_SH  = 6'd7;
    localparam logic [5:0] OP_SW  = 6'd8;

    typedef enum logic [1:0] {IDLE, REQ, WAIT, DONE} state_t;
    state_t state_q, state_d;

    logic              m_valid, m_ren, m_wen;
    logic [5:0]        m_op;
    logic [ADDR_W-1:0] m_addr;
    logic [31:0]       m_wdata;

    logic              nxt_valid, nxt_ren, nxt_wen;
    logic [5:0]        nxt_op;
    logic [ADDR_W-1:0] nxt_addr;
    logic [31:0]       nxt_wdata, nxt_wrep;
    logic [1:0]        nxt_size;

    logic              b_ren, b_wr;
    logic [5:0]        b_op;
    logic [1:0]        b_size;
    logic [ADDR_W-1:0] b_addr;
    logic [31:0]       b_wdata;

    logic              cancel_q, cancel_eff;
    logic              issue, finish, req;
    logic [7:0]        byte_sel;
    logic [15:0]       half_sel;
    logic [31:0]       ext, rdata_q;

    // M pipeline register: flush kills, advance loads the E-stage access
    always_ff @(posedge clk) begin
        if (rst) begin
            m_valid <= 1'b0;
            m_ren   <= 1'b0;
            m_wen   <= 1'b0;
            m_op    <= '0;
            m_addr  <= '0;
            m_wdata <= '0;
        end else if (M_flush) begin
            m_valid <= 1'b0;
        end else if (M_ena) begin
            m_valid <= E_mem_en;
            m_ren   <= E_mem_ren;
            m_wen   <= E_mem_wen;
            m_op    <= E_mem_op;
            m_addr  <= E_mem_addr;
            m_wdata <= E_mem_wdata;
        end
    end

    // Contents M will hold after this edge, so an op can issue as it enters M
    always_comb begin
        nxt_valid = M_flush ? 1'b0 : (M_ena ? E_mem_en : m_valid);
        nxt_ren   = (M_ena & ~M_flush) ? E_mem_ren   : m_ren;
        nxt_wen   = (M_ena & ~M_flush) ? E_mem_wen   : m_wen;
        nxt_op    = (M_ena & ~M_flush) ? E_mem_op    : m_op;
        nxt_addr  = (M_ena & ~M_flush) ? E_mem_addr  : m_addr;
        nxt_wdata = (M_ena & ~M_flush) ? E_mem_wdata : m_wdata;
        unique case (nxt_op)
            OP_LB, OP_LBU, OP_SB: nxt_size = 2'd0;
            OP_LH, OP_LHU, OP_SH: nxt_size = 2'd1;
            default:              nxt_size = 2'd2;
        endcase
        unique case (nxt_op)
            OP_SB:   nxt_wrep = {4{nxt_wdata[7:0]}};
            OP_SH:   nxt_wrep = {2{nxt_wdata[15:0]}};
            default: nxt_wrep = nxt_wdata;
        endcase
    end

    // FSM state register
    always_ff @(posedge clk) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    // FSM next state; a flushed transaction still completes, then drops its data
    always_comb begin
        state_d    = state_q;
        issue      = 1'b0;
        finish     = 1'b0;
        req        = 1'b0;
        cancel_eff = cancel_q | M_flush;
        unique case (state_q)
            IDLE: begin
                if (nxt_valid) begin
                    state_d = REQ;
                    issue   = 1'b1;
                end
            end
            REQ: begin
                req = 1'b1;
                if (bus.data_addr_ok) begin
                    if (bus.data_data_ok) begin
                        finish  = 1'b1;
                        state_d = cancel_eff ? IDLE : DONE;
                    end else begin
                        state_d = WAIT;
                    end
                end
            end
            WAIT: begin
                if (bus.data_data_ok) begin
                    finish  = 1'b1;
                    state_d = cancel_eff ? IDLE : DONE;
                end
            end
            DONE: begin
                if (M_ena | M_flush) begin
                    state_d = nxt_valid ? REQ : IDLE;
                    issue   = nxt_valid;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Cancel marks an in-flight transaction whose M-stage owner was flushed
    always_ff @(posedge clk) begin
        if (rst)
            cancel_q <= 1'b0;
        else if (finish)
            cancel_q <= 1'b0;
        else if (M_flush && (state_q == REQ || state_q == WAIT))
            cancel_q <= 1'b1;
    end

    // Bus fields latched at issue so they stay stable while the request is open
    always_ff @(posedge clk) begin
        if (rst) begin
            b_ren   <= 1'b0;
            b_wr    <= 1'b0;
            b_op    <= '0;
            b_size  <= '0;
            b_addr  <= '0;
            b_wdata <= '0;
        end else if (issue) begin
            b_ren   <= nxt_ren;
            b_wr    <= nxt_wen;
            b_op    <= nxt_op;
            b_size  <= nxt_size;
            b_addr  <= nxt_addr;
            b_wdata <= nxt_wrep;
        end
    end

    // Lane select and sign/zero extension of the returned word
    always_comb begin
        unique case (b_addr[1:0])
            2'd0:    byte_sel = bus.data_rdata[7:0];
            2'd1:    byte_sel = bus.data_rdata[15:8];
            2'd2:    byte_sel = bus.data_rdata[23:16];
            default: byte_sel = bus.data_rdata[31:24];
        endcase
        half_sel = b_addr[1] ? bus.data_rdata[31:16] : bus.data_rdata[15:0];
        unique case (b_op)
            OP_LB:   ext = {{24{byte_sel[7]}}, byte_sel};
            OP_LBU:  ext = {24'd0, byte_sel};
            OP_LH:   ext = {{16{half_sel[15]}}, half_sel};
            OP_LHU:  ext = {16'd0, half_sel};
            OP_LW:   ext = bus.data_rdata;
            default: ext = bus.data_rdata;
        endcase
    end

    // Load result capture; stores and cancelled accesses leave nothing behind
    always_ff @(posedge clk) begin
        if (rst)
            rdata_q <= '0;
        else if (finish && !cancel_eff)
            rdata_q <= b_ren ? ext : 32'd0;
    end

    assign bus.data_req   = req;
    assign bus.data_wr    = b_wr;
    assign bus.data_size  = b_size;
    assign bus.data_addr  = b_addr;
    assign bus.data_wdata = b_wdata;
    assign M_mem_rdata    = rdata_q;
    assign d_stall        = m_valid & (state_q != DONE);
endmodule

// File: tb/tb_mem_access_ctrl.sv
// Directed bench for mem_access_ctrl: load extension, store replication,
// bus wait states, flush/cancel ordering, back-to-back ops and reset.
module tb_mem_access_ctrl;
    localparam logic [5:0] OP_LB  = 6'd1;
    localparam logic [5:0] OP_LBU = 6'd2;
    localparam logic [5:0] OP_LH  = 6'd3;
    localparam logic [5:0] OP_LHU = 6'd4;
    localparam logic [5:0] OP_LW  = 6'd5;
    localparam logic [5:0] OP_SW  = 6'd8;
    localparam logic [5:0] OP_SH  = 6'd7;

    logic        clk = 1'b0;
    logic        rst;
    logic        M_ena, M_flush;
    logic        E_mem_en, E_mem_ren, E_mem_wen;
    logic [5:0]  E_mem_op;
    logic [31:0] E_mem_addr, E_mem_wdata;
    logic [31:0] M_mem_rdata;
    logic        d_stall;

    int checks = 0;
    int errors = 0;

    mem_access_ctrl_if #(.ADDR_W(32)) bus ();

    mem_access_ctrl #(.ADDR_W(32)) dut (
        .clk         (clk),
        .rst         (rst),
        .M_ena       (M_ena),
        .M_flush     (M_flush),
        .E_mem_en    (E_mem_en),
        .E_mem_ren   (E_mem_ren),
        .E_mem_wen   (E_mem_wen),
        .E_mem_op    (E_mem_op),
        .E_mem_addr  (E_mem_addr),
        .E_mem_wdata (E_mem_wdata),
        .bus         (bus),
        .M_mem_rdata (M_mem_rdata),
        .d_stall     (d_stall)
    );

    always #5 clk = ~clk;

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic load_op(input logic [5:0] op, input logic [31:0] addr,
                           input logic ren, input logic [31:0] wd);
        M_ena       = 1'b1;
        E_mem_en    = 1'b1;
        E_mem_ren   = ren;
        E_mem_wen   = ~ren;
        E_mem_op    = op;
        E_mem_addr  = addr;
        E_mem_wdata = wd;
    endtask

    task automatic hold();
        M_ena    = 1'b0;
        E_mem_en = 1'b0;
    endtask

    task automatic run_load(input string tag, input logic [5:0] op, input logic [31:0] addr,
                            input logic [31:0] rd, input logic [1:0] size,
                            input logic [31:0] exp);
        load_op(op, addr, 1'b1, 32'd0);
        bus.data_addr_ok = 1'b1;
        bus.data_data_ok = 1'b1;
        bus.data_rdata   = rd;
        cyc();
        chk({tag, "_stall"}, 32'(d_stall), 32'd1);
        chk({tag, "_req"}, 32'(bus.data_req), 32'd1);
        chk({tag, "_size"}, 32'(bus.data_size), 32'(size));
        chk({tag, "_addr"}, bus.data_addr, addr);
        hold();
        cyc();
        chk({tag, "_nostall"}, 32'(d_stall), 32'd0);
        chk({tag, "_rdata"}, M_mem_rdata, exp);
    endtask

    initial begin
        rst = 1'b1;
        M_ena = 1'b0; M_flush = 1'b0;
        E_mem_en = 1'b0; E_mem_ren = 1'b0; E_mem_wen = 1'b0;
        E_mem_op = '0; E_mem_addr = '0; E_mem_wdata = '0;
        bus.data_addr_ok = 1'b0;
        bus.data_data_ok = 1'b0;
        bus.data_rdata   = '0;
        cyc();
        cyc();
        chk("rst_req", 32'(bus.data_req), 32'd0);
        chk("rst_stall", 32'(d_stall), 32'd0);
        chk("rst_rdata", M_mem_rdata, 32'd0);
        chk("rst_wr", 32'(bus.data_wr), 32'd0);
        chk("rst_addr", bus.data_addr, 32'd0);
        rst = 1'b0;
        cyc();

        run_load("lw", OP_LW, 32'h0000_1000, 32'hDEAD_BEEF, 2'd2, 32'hDEAD_BEEF);
        run_load("lb", OP_LB, 32'h0000_1003, 32'h80FF_0000, 2'd0, 32'hFFFF_FF80);
        run_load("lbu", OP_LBU, 32'h0000_1003, 32'h80FF_0000, 2'd0, 32'h0000_0080);
        run_load("lh", OP_LH, 32'h0000_1002, 32'h80FF_0000, 2'd1, 32'hFFFF_80FF);

        // SH with addr_ok held off for three request cycles
        load_op(OP_SH, 32'h0000_2002, 1'b0, 32'h1234_ABCD);
        bus.data_addr_ok = 1'b0;
        bus.data_data_ok = 1'b0;
        cyc();
        hold();
        E_mem_op = OP_LW; E_mem_addr = 32'hFFFF_FFF0; E_mem_wdata = 32'h5555_5555;
        for (int i = 0; i < 3; i++) begin
            chk("sh_req", 32'(bus.data_req), 32'd1);
            chk("sh_wdata", bus.data_wdata, 32'hABCD_ABCD);
            chk("sh_addr", bus.data_addr, 32'h0000_2002);
            chk("sh_size", 32'(bus.data_size), 32'd1);
            chk("sh_wr", 32'(bus.data_wr), 32'd1);
            chk("sh_stall", 32'(d_stall), 32'd1);
            if (i == 2) bus.data_addr_ok = 1'b1;
            cyc();
        end
        chk("sh_wait_req", 32'(bus.data_req), 32'd0);
        chk("sh_wait_stall", 32'(d_stall), 32'd1);
        bus.data_addr_ok = 1'b0;
        bus.data_data_ok = 1'b1;
        cyc();
        chk("sh_done_stall", 32'(d_stall), 32'd0);
        chk("sh_rdata", M_mem_rdata, 32'd0);

        // Flush while waiting for data, then a new LW must wait for that data_ok
        load_op(OP_LW, 32'h0000_3000, 1'b1, 32'd0);
        bus.data_addr_ok = 1'b1;
        bus.data_data_ok = 1'b0;
        cyc();
        hold();
        cyc();
        chk("fl_wait_req", 32'(bus.data_req), 32'd0);
        chk("fl_wait_stall", 32'(d_stall), 32'd1);
        bus.data_addr_ok = 1'b0;
        M_flush = 1'b1;
        cyc();
        M_flush = 1'b0;
        chk("fl_flushed_stall", 32'(d_stall), 32'd0);
        load_op(OP_LW, 32'h0000_4000, 1'b1, 32'd0);
        cyc();
        hold();
        chk("fl_new_req", 32'(bus.data_req), 32'd0);
        chk("fl_new_stall", 32'(d_stall), 32'd1);
        cyc();
        chk("fl_hold_req", 32'(bus.data_req), 32'd0);
        bus.data_data_ok = 1'b1;
        bus.data_rdata   = 32'hBAD0_BAD0;
        cyc();
        bus.data_data_ok = 1'b0;
        chk("fl_drop_req", 32'(bus.data_req), 32'd0);
        chk("fl_drop_stall", 32'(d_stall), 32'd1);
        chk("fl_drop_rdata", M_mem_rdata, 32'd0);
        cyc();
        chk("fl_reissue_req", 32'(bus.data_req), 32'd1);
        chk("fl_reissue_addr", bus.data_addr, 32'h0000_4000);
        bus.data_addr_ok = 1'b1;
        bus.data_data_ok = 1'b1;
        bus.data_rdata   = 32'h1357_9BDF;
        cyc();
        chk("fl_done_stall", 32'(d_stall), 32'd0);
        chk("fl_done_rdata", M_mem_rdata, 32'h1357_9BDF);

        // Back-to-back LW/SW/LW with an always-ready bus
        run_load("b2b_lw0", OP_LW, 32'h0000_5000, 32'h1111_2222, 2'd2, 32'h1111_2222);
        load_op(OP_SW, 32'h0000_5004, 1'b0, 32'hCAFE_F00D);
        cyc();
        chk("b2b_sw_req", 32'(bus.data_req), 32'd1);
        chk("b2b_sw_wr", 32'(bus.data_wr), 32'd1);
        chk("b2b_sw_wdata", bus.data_wdata, 32'hCAFE_F00D);
        chk("b2b_sw_stall", 32'(d_stall), 32'd1);
        hold();
        cyc();
        chk("b2b_sw_nostall", 32'(d_stall), 32'd0);
        chk("b2b_sw_rdata", M_mem_rdata, 32'd0);
        run_load("b2b_lw1", OP_LW, 32'h0000_5008, 32'h3333_4444, 2'd2, 32'h3333_4444);
        M_ena = 1'b1;
        cyc();
        M_ena = 1'b0;
        chk("b2b_idle_req", 32'(bus.data_req), 32'd0);
        chk("b2b_idle_stall", 32'(d_stall), 32'd0);

        // Reset while waiting on data
        load_op(OP_LW, 32'h0000_6000, 1'b1, 32'd0);
        bus.data_addr_ok = 1'b1;
        bus.data_data_ok = 1'b0;
        cyc();
        hold();
        cyc();
        chk("rw_wait_stall", 32'(d_stall), 32'd1);
        rst = 1'b1;
        bus.data_addr_ok = 1'b0;
        cyc();
        rst = 1'b0;
        chk("rw_req", 32'(bus.data_req), 32'd0);
        chk("rw_stall", 32'(d_stall), 32'd0);
        chk("rw_rdata", M_mem_rdata, 32'd0);
        cyc();
        chk("rw_idle_req", 32'(bus.data_req), 32'd0);

        run_load("lhu", OP_LHU, 32'h0000_7002, 32'h80FF_1234, 2'd1, 32'h0000_80FF);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
